// File: rtl/load_store_unit.sv
// Purpose: MEM-stage load/store initiator for a word-wide, synchronous-read data memory (no byte enables).
// Latency: SW responds T+1 without stalling; loads and SB/SH respond at T+2; faults pulse at T+1.
// Backpressure: busy is high outside IDLE; req_valid is ignored while busy and the pipeline holds its request.
// Ports: clk/reset (sync, active-high); req_* pipeline request; busy/resp_valid/resp_rdata/fault back to pipeline;
//        MemRead/MemWrite/mem_addr/mem_wdata drive the memory, mem_rdata returns one cycle after MemRead.
// Macro LSU_MISALIGN_TRAP_EN: defined -> misaligned accesses fault; undefined -> address forced to natural alignment.
module load_store_unit #(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        fault,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [15:0] wdata_q;
    logic [29:0] word_q;

    logic        legal;
    logic        oor;
    logic        req_fault;
    logic [1:0]  req_lo;
    logic        is_sw;
    logic        go;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Request decode
    always_comb begin
        legal     = 1'b0;
        oor       = |req_addr[31:MEM_ADDR_BITS];
        req_fault = 1'b0;
        req_lo    = req_addr[1:0];
        if (req_write)
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef LSU_MISALIGN_TRAP_EN
        req_fault = !legal || oor ||
                    (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        // Misalignment is silently corrected by dropping the low offset bits.
        req_fault = !legal || oor;
        case (req_funct3[1:0])
            2'b01:   req_lo = {req_addr[1], 1'b0};
            2'b10:   req_lo = 2'b00;
            default: req_lo = req_addr[1:0];
        endcase
`endif
    end

    assign is_sw = req_write && (req_funct3[1:0] == 2'b10);
    assign go    = (state == IDLE) && req_valid && !req_fault && !reset;
    assign busy  = (state != IDLE);

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (lo_q)
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            2'd3:    sel_byte = mem_rdata[31:24];
            default: sel_byte = mem_rdata[7:0];
        endcase
        sel_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (f3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'b0, sel_byte};
            3'b101:  load_data = {16'b0, sel_half};
            default: load_data = mem_rdata;
        endcase

        merge_data = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            case (lo_q)
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (lo_q[1]) begin
            merge_data[31:16] = wdata_q;
        end else begin
            merge_data[15:0] = wdata_q;
        end
    end

    // Memory strobes: straight from the request in IDLE, from the latched copy
    // afterwards. Gating on reset keeps an interrupted RMW from writing.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (go) begin
                        mem_addr = {req_addr[31:2], 2'b00};
                        MemRead  = !is_sw;
                        MemWrite = is_sw;
                        if (is_sw)
                            mem_wdata = req_wdata;
                    end
                end
                RMW_WAIT: begin
                    mem_addr  = {word_q, 2'b00};
                    MemWrite  = 1'b1;
                    mem_wdata = merge_data;
                end
                default: mem_addr = {word_q, 2'b00};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            resp_rdata <= 32'b0;
            f3_q       <= 3'b0;
            lo_q       <= 2'b0;
            wdata_q    <= 16'b0;
            word_q     <= 30'b0;
        end else begin
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_fault) begin
                            fault <= 1'b1;
                        end else begin
                            f3_q    <= req_funct3;
                            lo_q    <= req_lo;
                            wdata_q <= req_wdata[15:0];
                            word_q  <= req_addr[31:2];
                            if (is_sw)
                                resp_valid <= 1'b1;
                            else
                                state <= req_write ? RMW_WAIT : LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    resp_rdata <= load_data;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_WAIT: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte-array model plus per-cycle expectation tables,
// one compare process checks every cycle; directed cases then randomized traffic.
module tb_load_store_unit;

    localparam int N = 4096;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_ADDR_BITS(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory seen by the DUT, with a backdoor preload port.
    logic [31:0] ram [0:255];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;
    always @(posedge clk) begin
        if (pl_en)
            ram[pl_a] <= pl_d;
        else if (MemWrite)
            ram[mem_addr[9:2]] <= mem_wdata;
        if (MemRead)
            mem_rdata <= ram[mem_addr[9:2]];
    end

    // Architectural model and per-cycle expectations
    logic [7:0]  mb [0:1023];
    bit          e_busy [0:N-1];
    bit          e_rd   [0:N-1];
    bit          e_wr   [0:N-1];
    bit          e_resp [0:N-1];
    bit          e_fault[0:N-1];
    bit          e_rdv  [0:N-1];
    logic [31:0] e_addr [0:N-1];
    logic [31:0] e_wdat [0:N-1];
    logic [31:0] e_rdnew[0:N-1];

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          checking = 1'b0;
    logic [31:0] exp_rd = 32'b0;
    int          free_at = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %08h, expected %08h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_fault(input bit w, input bit [2:0] f3, input bit [31:0] a);
        bit legal;
        bit mis;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
        return !legal || (a >= 32'd1024) || (TRAP && mis);
    endfunction

    function automatic bit [31:0] m_align(input bit [2:0] f3, input bit [31:0] a);
        if (f3[1:0] == 2'd1) return {a[31:1], 1'b0};
        if (f3[1:0] == 2'd2) return {a[31:2], 2'b00};
        return a;
    endfunction

    function automatic bit [31:0] m_word(input int wi);
        return {mb[4*wi+3], mb[4*wi+2], mb[4*wi+1], mb[4*wi]};
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a);
        bit [7:0]  b;
        bit [15:0] h;
        b = mb[a];
        h = {mb[a+1], mb[a]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'b0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'b0, h};
            default: return m_word(int'(a >> 2));
        endcase
    endfunction

    // Compare process: every cycle once checking starts.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (checking && cyc < N) begin
                if (e_rdv[cyc]) exp_rd = e_rdnew[cyc];
                chk("busy",       {31'b0, busy},       {31'b0, e_busy[cyc]});
                chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_resp[cyc]});
                chk("fault",      {31'b0, fault},      {31'b0, e_fault[cyc]});
                chk("MemRead",    {31'b0, MemRead},    {31'b0, e_rd[cyc]});
                chk("MemWrite",   {31'b0, MemWrite},   {31'b0, e_wr[cyc]});
                if (e_rd[cyc] || e_wr[cyc]) chk("mem_addr", mem_addr, e_addr[cyc]);
                if (e_wr[cyc]) chk("mem_wdata", mem_wdata, e_wdat[cyc]);
                chk("resp_rdata", resp_rdata, exp_rd);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input int wi, input bit [31:0] v);
        pl_en = 1'b1;
        pl_a  = wi[7:0];
        pl_d  = v;
        for (int i = 0; i < 4; i++) mb[4*wi+i] = v[8*i +: 8];
        step();
        pl_en = 1'b0;
    endtask

    // Presents a request, holds it until the model says the unit is idle, records
    // what the unit must do from the accept cycle T onward. Returns at T+1.
    task automatic issue(input bit w, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit abort);
        bit [31:0] ea;
        int        t;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (cyc < free_at) step();
        t = cyc;
        if (m_fault(w, f3, a)) begin
            e_fault[t+1] = 1'b1;
            free_at = t + 1;
        end else begin
            ea = m_align(f3, a);
            e_addr[t] = {a[31:2], 2'b00};
            if (w && f3[1:0] == 2'd2) begin
                e_wr[t]     = 1'b1;
                e_wdat[t]   = wd;
                e_resp[t+1] = 1'b1;
                for (int i = 0; i < 4; i++) mb[ea+i] = wd[8*i +: 8];
                free_at = t + 1;
            end else begin
                e_rd[t]     = 1'b1;
                e_busy[t+1] = 1'b1;
                e_busy[t+2] = 1'b1;
                e_resp[t+2] = 1'b1;
                free_at = t + 3;
                if (w && abort) begin
                    e_busy[t+2]  = 1'b0;
                    e_resp[t+2]  = 1'b0;
                    e_rdv[t+2]   = 1'b1;
                    e_rdnew[t+2] = 32'b0;
                    free_at = t + 2;
                end else if (w) begin
                    mb[ea] = wd[7:0];
                    if (f3[1:0] == 2'd1) mb[ea+1] = wd[15:8];
                    e_wr[t+1]   = 1'b1;
                    e_addr[t+1] = {a[31:2], 2'b00};
                    e_wdat[t+1] = m_word(int'(ea >> 2));
                end else begin
                    e_rdv[t+2]   = 1'b1;
                    e_rdnew[t+2] = m_load(f3, ea);
                end
            end
        end
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] a;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0;
        pl_en = 1'b0; pl_a = 8'b0; pl_d = 32'b0;
        step();
        step();
        checking = 1'b1;  // reset state checked while reset is still high
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        reset = 1'b0;
        step();

        // Sub-word loads
        preload(4, 32'h80FF7F01);
        chk("model_lb_11",  m_load(3'd0, 32'h11), 32'h0000007F);
        chk("model_lb_13",  m_load(3'd0, 32'h13), 32'hFFFFFF80);
        chk("model_lbu_13", m_load(3'd4, 32'h13), 32'h00000080);
        chk("model_lh_12",  m_load(3'd1, 32'h12), 32'hFFFF80FF);
        issue(1'b0, 3'd0, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b0);

        // SW then LW back-to-back, then the misaligned LW
        issue(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
        chk("model_lw_20", m_load(3'd2, 32'h20), 32'hDEADBEEF);
        if (!TRAP) chk("model_lw_22_aligned", m_load(3'd2, m_align(3'd2, 32'h22)), 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h22, 32'h0, 1'b0);

        // SB read-modify-write
        preload(8, 32'h11223344);
        issue(1'b1, 3'd0, 32'h21, 32'h000000AA, 1'b0);
        chk("model_sb_merge", m_word(8), 32'h1122AA44);

        // Faults
        chk("model_fault_lw22",  {31'b0, m_fault(1'b0, 3'd2, 32'h22)},  {31'b0, TRAP});
        chk("model_fault_sh05",  {31'b0, m_fault(1'b1, 3'd1, 32'h05)},  {31'b0, TRAP});
        chk("model_fault_f3_3",  {31'b0, m_fault(1'b0, 3'd3, 32'h10)},  32'd1);
        chk("model_fault_lw400", {31'b0, m_fault(1'b0, 3'd2, 32'h400)}, 32'd1);
        issue(1'b1, 3'd1, 32'h05, 32'h00001234, 1'b0);
        issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 3'd2, 32'h400, 32'h0, 1'b0);
        issue(1'b1, 3'd7, 32'h40, 32'h0, 1'b0);

        // Reset while in RMW_WAIT
        preload(12, 32'h01020304);
        issue(1'b1, 3'd1, 32'h30, 32'h0000BEEF, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        chk("ram_after_abort", ram[12], 32'h01020304);

        // Held request under stall
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h44, 32'h13572468, 1'b0);
        issue(1'b1, 3'd2, 32'h48, 32'h2468ACE0, 1'b0);
        issue(1'b0, 3'd2, 32'h44, 32'h0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 15) == 0) a[20] = 1'b1;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (5) step();
        for (int i = 0; i < 256; i++) chk("ram_final", ram[i], m_word(i));
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
